// File: rtl/ext_mem_pkg.sv
// Shared types and elaboration helpers for the external memory bridge.
// Beat counts derive from data/address widths over the pin bus width.
package ext_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RWAIT,
    RGAP,
    RESP
  } state_e;

  function automatic int beat_cnt(input int w, input int bus);
    return w / bus;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit width_ok(input int w, input int bus);
    return (bus > 0) && (w >= bus) && (w % bus == 0);
  endfunction

endpackage

// File: rtl/ext_mem_beat_timer.sv
// Loadable down-counter shared by beat settle hold and read timeout.
// Parks at zero; zero_o marks the last cycle of a hold/wait window.
module ext_mem_beat_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ext_mem_bridge.sv
// Request-port to byte-serial MCU memory bridge: address beats, then
// write beats or ack-edge-qualified read beats with timeout.
module ext_mem_bridge
  import ext_mem_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int BUS_W          = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      req_valid,
  output logic                                      req_ready,
  input  logic                                      req_write,
  input  logic [ADDR_W-1:0]                         req_addr,
  input  logic [DATA_W-1:0]                         req_wdata,
  output logic                                      rsp_valid,
  input  logic                                      rsp_ready,
  output logic [DATA_W-1:0]                         rsp_rdata,
  output logic                                      rsp_error,
  output logic                                      ext_we,
  output logic                                      ext_re,
  output logic                                      ext_addr_phase,
  output logic [max_int(ADDR_W/BUS_W, DATA_W/BUS_W)-1:0] ext_beat_sel,
  output logic [BUS_W-1:0]                          ext_dout,
  input  logic [BUS_W-1:0]                          ext_din,
  input  logic                                      ext_ack
);

  localparam int AB = beat_cnt(ADDR_W, BUS_W);
  localparam int DB = beat_cnt(DATA_W, BUS_W);
  localparam int NB = max_int(AB, DB);
  localparam int IW = idx_width(NB);
  localparam int TW =
    $clog2(max_int(SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [TW-1:0] SET_LD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LD  = TW'(TIMEOUT_CYCLES - 1);

  if (!width_ok(ADDR_W, BUS_W) || !width_ok(DATA_W, BUS_W) ||
      SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("ext_mem_bridge: illegal width or cycle parameters");
  end

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                wr_q, wr_d;
  logic                err_q, err_d;
  logic                ack_q;
  logic                rdy_en_q;

  logic                tmr_load;
  logic [TW-1:0]       tmr_val;
  logic                tmr_zero;
  logic [31:0]         sh;
  logic                ack_edge;
  logic                last_a;
  logic                last_d;
  logic                busy;

  ext_mem_beat_timer #(.W(TW)) u_timer (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .zero_o (tmr_zero)
  );

  assign sh       = BUS_W * 32'(idx_q);
  assign ack_edge = ext_ack && !ack_q;
  assign last_a   = (idx_q == IW'(AB - 1));
  assign last_d   = (idx_q == IW'(DB - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      ack_q    <= ext_ack;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    wr_d     = wr_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_val  = SET_LD;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          wr_d     = req_write;
          rdata_d  = '0;
          err_d    = 1'b0;
          idx_d    = '0;
          tmr_load = 1'b1;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (last_a) begin
            idx_d   = '0;
            state_d = wr_q ? WDATA : RWAIT;
            if (!wr_q) tmr_val = TO_LD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WDATA: begin
        if (tmr_zero) begin
          if (last_d) begin
            state_d = RESP;
          end else begin
            idx_d    = idx_q + 1'b1;
            tmr_load = 1'b1;
          end
        end
      end
      RWAIT: begin
        // A capture on the final timeout cycle still wins over the abort.
        if (ack_edge) begin
          rdata_d = rdata_q | (DATA_W'(ext_din) << sh);
          state_d = last_d ? RESP : RGAP;
        end else if (tmr_zero) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RGAP: begin
        idx_d    = idx_q + 1'b1;
        tmr_load = 1'b1;
        tmr_val  = TO_LD;
        state_d  = RWAIT;
      end
      RESP: begin
        if (rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready      = (state_q == IDLE) && rdy_en_q;
    rsp_valid      = (state_q == RESP);
    rsp_rdata      = rsp_valid ? rdata_q : '0;
    rsp_error      = rsp_valid && err_q;
    busy           = state_q inside {ADDR, WDATA, RWAIT, RGAP};
    ext_we         = busy && wr_q;
    ext_re         = busy && !wr_q;
    ext_addr_phase = (state_q == ADDR);
    ext_beat_sel   = '0;
    ext_dout       = '0;
    unique case (1'b1)
      (state_q == ADDR): begin
        ext_beat_sel = NB'(1) << idx_q;
        ext_dout     = BUS_W'(addr_q >> sh);
      end
      (state_q == WDATA): begin
        ext_beat_sel = NB'(1) << idx_q;
        ext_dout     = BUS_W'(wdata_q >> sh);
      end
      (state_q == RWAIT): begin
        ext_beat_sel = NB'(1) << idx_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ext_mem_bridge.sv
// Directed bench: default 16/16/8 bridge plus a 24/32/8 single-cycle
// settle instance; inputs change and outputs are sampled on negedge.
module tb_ext_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_wdata, rsp_rdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic        ext_we, ext_re, ext_addr_phase, ext_ack;
  logic [1:0]  ext_beat_sel;
  logic [7:0]  ext_dout, ext_din;

  logic        v2, rdy2, wr2, rv2, rr2, err2;
  logic        we2, re2, ph2, ack2;
  logic [23:0] addr2;
  logic [31:0] wd2, rd2;
  logic [3:0]  sel2;
  logic [7:0]  dout2, din2;

  int total = 0;
  int bad   = 0;

  ext_mem_bridge dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .ext_we(ext_we), .ext_re(ext_re),
    .ext_addr_phase(ext_addr_phase),
    .ext_beat_sel(ext_beat_sel), .ext_dout(ext_dout),
    .ext_din(ext_din), .ext_ack(ext_ack)
  );

  ext_mem_bridge #(
    .ADDR_W(24), .DATA_W(32), .BUS_W(8), .SETTLE_CYCLES(1)
  ) dut2 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(v2), .req_ready(rdy2),
    .req_write(wr2), .req_addr(addr2),
    .req_wdata(wd2), .rsp_valid(rv2),
    .rsp_ready(rr2), .rsp_rdata(rd2),
    .rsp_error(err2), .ext_we(we2), .ext_re(re2),
    .ext_addr_phase(ph2),
    .ext_beat_sel(sel2), .ext_dout(dout2),
    .ext_din(din2), .ext_ack(ack2)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic v, input logic ph,
                                     input logic we, input logic re,
                                     input logic [3:0] sel,
                                     input logic [7:0] d);
    return {48'b0, v, ph, we, re, sel, d};
  endfunction

  function automatic logic [63:0] o1();
    return mk(rsp_valid, ext_addr_phase, ext_we, ext_re,
              4'(ext_beat_sel), ext_dout);
  endfunction

  function automatic logic [63:0] o2();
    return mk(rv2, ph2, we2, re2, sel2, dout2);
  endfunction

  logic [7:0] wb [4];
  logic [7:0] b2 [7];
  logic [3:0] s2 [7];

  initial begin
    wb = '{8'hAB, 8'h12, 8'hEF, 8'hBE};
    b2 = '{8'h12, 8'h34, 8'h56, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    s2 = '{4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h4, 4'h8};
    reset_n = 1'b0;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    rsp_ready = 0; ext_din = '0; ext_ack = 0;
    v2 = 0; wr2 = 0; addr2 = '0; wd2 = '0; rr2 = 1; din2 = '0;
    ack2 = 0;

    // reset
    repeat (2) @(negedge clk);
    chk("rst_outs", o1(), mk(0, 0, 0, 0, 0, 0));
    chk("rst_rdy", {req_ready, rsp_error, rsp_rdata}, '0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", {req_ready, rdy2}, 2'b11);

    // write 0x12AB <- 0xBEEF
    req_valid = 1; req_write = 1;
    req_addr = 16'h12AB; req_wdata = 16'hBEEF;
    @(negedge clk);
    req_valid = 0; req_addr = '0; req_wdata = '0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("wr_beat%0d", k), o1(),
          mk(0, k < 8, 1, 0, 4'(1 << ((k / 4) % 2)), wb[k / 4]));
      @(negedge clk);
    end
    chk("wr_rsp", o1(), mk(1, 0, 0, 0, 0, 0));
    chk("wr_rsp_data", {req_ready, rsp_error, rsp_rdata}, '0);

    // response held off; new read request must wait
    req_valid = 1; req_write = 0; req_addr = 16'h0040;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d", k),
          {rsp_valid, req_ready, ext_re}, 3'b100);
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("hold_release", {rsp_valid, req_ready, ext_re}, 3'b010);
    rsp_ready = 0;

    // read 0x0040, acks 0x34 then 0x12
    @(negedge clk);
    chk("rd_addr0", o1(), mk(0, 1, 0, 1, 1, 8'h40));
    req_valid = 0; req_addr = 16'hFFFF;
    repeat (7) @(negedge clk);
    chk("rd_addr1", o1(), mk(0, 1, 0, 1, 2, 8'h00));
    @(negedge clk);
    chk("rd_wait0", o1(), mk(0, 0, 0, 1, 1, 0));
    ext_din = 8'h34; ext_ack = 1;
    @(negedge clk);
    chk("rd_gap", o1(), mk(0, 0, 0, 1, 0, 0));
    ext_ack = 0; ext_din = 8'h00;
    @(negedge clk);
    chk("rd_wait1", o1(), mk(0, 0, 0, 1, 2, 0));
    repeat (2) @(negedge clk);
    ext_din = 8'h12; ext_ack = 1;
    @(negedge clk);
    chk("rd_rsp", o1(), mk(1, 0, 0, 0, 0, 0));
    chk("rd_data", {rsp_error, rsp_rdata}, {1'b0, 16'h1234});
    ext_ack = 0; rsp_ready = 1;
    @(negedge clk);
    chk("rd_idle", {rsp_valid, req_ready}, 2'b01);

    // read with level ack over both beats, then timeout
    req_valid = 1; req_write = 0; req_addr = 16'h0041;
    @(negedge clk);
    req_valid = 0;
    repeat (8) @(negedge clk);
    chk("to_wait0", o1(), mk(0, 0, 0, 1, 1, 0));
    ext_din = 8'h5A; ext_ack = 1;
    repeat (10) @(negedge clk);
    chk("to_beat1", o1(), mk(0, 0, 0, 1, 2, 0));
    ext_ack = 0;
    repeat (246) @(negedge clk);
    chk("to_last_wait", o1(), mk(0, 0, 0, 1, 2, 0));
    req_valid = 1; req_write = 1;
    req_addr = 16'h0102; req_wdata = 16'h0304;
    @(negedge clk);
    chk("to_rsp", o1(), mk(1, 0, 0, 0, 0, 0));
    chk("to_err", {req_ready, rsp_error, rsp_rdata}, {2'b01, 16'h0});
    @(negedge clk);
    chk("b2b_idle", {rsp_valid, req_ready}, 2'b01);

    // write then reset during WDATA beat 1
    @(negedge clk);
    chk("rw_addr0", o1(), mk(0, 1, 1, 0, 1, 8'h02));
    req_valid = 0;
    repeat (13) @(negedge clk);
    chk("rw_wdata1", o1(), mk(0, 0, 1, 0, 2, 8'h03));
    reset_n = 0;
    @(negedge clk);
    chk("rw_rst_outs", o1(), mk(0, 0, 0, 0, 0, 0));
    chk("rw_rst_rdy", {req_ready, rsp_error, rsp_rdata}, '0);
    reset_n = 1;
    @(negedge clk);
    chk("rw_rel", {req_ready, o1()}, {1'b1, mk(0, 0, 0, 0, 0, 0)});
    repeat (20) @(negedge clk);
    chk("rw_no_rsp", {rsp_valid, req_ready}, 2'b01);

    // wide config: 7 single-cycle beats
    v2 = 1; wr2 = 1; addr2 = 24'h563412; wd2 = 32'hDDCCBBAA;
    @(negedge clk);
    v2 = 0; addr2 = '0; wd2 = '0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("w2_beat%0d", k), o2(),
          mk(0, k < 3, 1, 0, s2[k], b2[k]));
      @(negedge clk);
    end
    chk("w2_rsp", o2(), mk(1, 0, 0, 0, 0, 0));
    chk("w2_rsp_data", {err2, rd2}, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
